// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder and its storage array.
// Holds the FSM encoding, default geometry/latency and the byte-offset width.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int DEF_ADDR_W  = 10;
   localparam int DEF_LATENCY = 2;

   // Word index starts above the byte offset within a 32-bit word.
   localparam int BYTE_OFF_W  = 2;

endpackage

// File: rtl/dmem_array.sv
// Single-port 2^ADDR_W x 32 storage: synchronous write, registered read that is 0 unless read.
// One-cycle read latency; no backpressure, one access per cycle on the shared index.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] idx,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem [2**ADDR_W];

   // Storage is deliberately not reset; only the read register is.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= wdata;
      end
   end

   // Read register returns to zero on any cycle without a read, so the
   // responder's load data is zero outside its completion cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[idx];
      end else begin
         rdata <= '0;
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: holds stall through LATENCY wait cycles, then pulses ready for one cycle.
// Valid access completes in LATENCY+1 cycles, rejected access in 1; requester must hold inputs until ready.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int LATENCY = DEF_LATENCY
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_r,
   input  logic        mem_w,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        stall,
   output logic        err
);

   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   state_t            state;
   state_t            state_nx;
   logic [3:0]        cnt;
   logic [3:0]        cnt_nx;
   logic              ready_nx;
   logic              err_nx;
   logic              latch;
   logic              req_ok;
   logic              op_load;
   logic [ADDR_W-1:0] idx_q;
   logic [31:0]       wdata_q;
   logic              arr_we;
   logic              arr_re;
   logic              unused_addr_bits;

   // Upper address bits alias onto the array and are intentionally dropped.
   assign unused_addr_bits = ^addr[31:ADDR_W+BYTE_OFF_W];

   assign req_ok = (mem_r ^ mem_w) && (addr[BYTE_OFF_W-1:0] == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         ready <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         ready <= ready_nx;
         err   <= err_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_load <= 1'b0;
      end else if (latch) begin
         op_load <= mem_r;
      end
   end

   always_ff @(posedge clk) begin
      if (latch) begin
         idx_q   <= addr[ADDR_W+BYTE_OFF_W-1:BYTE_OFF_W];
         wdata_q <= wdata;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      ready_nx = 1'b0;
      err_nx   = 1'b0;
      latch    = 1'b0;
      arr_we   = 1'b0;
      arr_re   = 1'b0;
      stall    = 1'b0;
      case (state)
         IDLE: begin
            stall = mem_r | mem_w;
            if (mem_r | mem_w) begin
               if (req_ok) begin
                  latch    = 1'b1;
                  cnt_nx   = LAT_M1;
                  state_nx = WAIT;
               end else begin
                  ready_nx = 1'b1;
                  err_nx   = 1'b1;
                  state_nx = RESP;
               end
            end
         end
         WAIT: begin
            stall = 1'b1;
            if (cnt != 4'd0) begin
               cnt_nx = cnt - 4'd1;
            end else begin
               // Gate with reset so an edge that aborts the access cannot commit a store.
               arr_we   = !op_load && rst_n;
               arr_re   = op_load;
               ready_nx = 1'b1;
               state_nx = RESP;
            end
         end
         RESP: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   dmem_array #(
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (arr_we),
      .re    (arr_re),
      .idx   (idx_q),
      .wdata (wdata_q),
      .rdata (rdata)
   );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder at LATENCY 2, 1 and 15 sharing one clock and reset.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  mem_r;
   logic [2:0]  mem_w;
   logic [31:0] addr  [3];
   logic [31:0] wdata [3];
   logic [31:0] rdata [3];
   logic [2:0]  ready;
   logic [2:0]  stall;
   logic [2:0]  err;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   logic mon_en = 1'b0;

   typedef struct {
      int          dut;
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          issue;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_responder #(.ADDR_W(10), .LATENCY(2)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .mem_r(mem_r[0]), .mem_w(mem_w[0]), .addr(addr[0]),
      .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]), .stall(stall[0]), .err(err[0]));

   dmem_responder #(.ADDR_W(10), .LATENCY(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .mem_r(mem_r[1]), .mem_w(mem_w[1]), .addr(addr[1]),
      .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]), .stall(stall[1]), .err(err[1]));

   dmem_responder #(.ADDR_W(10), .LATENCY(15)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .mem_r(mem_r[2]), .mem_w(mem_w[2]), .addr(addr[2]),
      .wdata(wdata[2]), .rdata(rdata[2]), .ready(ready[2]), .stall(stall[2]), .err(err[2]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_tests++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   // Monitor: every ready pulse is matched against the oldest expected response.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         for (int d = 0; d < 3; d++) begin
            if (ready[d]) begin
               if (sb_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_ready: dut %0d got ready with no expected entry", d);
               end else begin
                  e = sb_q.pop_front();
                  chk("resp_dut", 32'(d), 32'(e.dut));
                  chk("resp_rdata", rdata[d], e.rd);
                  chk("resp_err", {31'b0, err[d]}, {31'b0, e.er});
                  chk("resp_latency", 32'(cyc - e.issue), 32'(e.lat));
                  chk("resp_stall_low", {31'b0, stall[d]}, 32'd0);
               end
            end else begin
               chk("idle_rdata_zero", rdata[d], 32'd0);
               chk("idle_err_zero", {31'b0, err[d]}, 32'd0);
            end
         end
      end
   end

   task automatic req(input int d, input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                      input int exp_lat);
      bit done;
      exp_t e;
      @(posedge clk);
      #1;
      mem_r[d] = r;
      mem_w[d] = w;
      addr[d]  = a;
      wdata[d] = wd;
      e = '{dut: d, rd: exp_rd, er: exp_err, lat: exp_lat, issue: cyc};
      sb_q.push_back(e);
      done = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (ready[d]) begin
            done = 1'b1;
            break;
         end
         chk("stall_busy", {31'b0, stall[d]}, 32'd1);
      end
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL ready_timeout: dut %0d no ready within 40 cycles, wanted %0d", d, exp_lat);
         sb_q.delete();
      end
      @(posedge clk);
      #1;
      mem_r[d] = 1'b0;
      mem_w[d] = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      mem_r = 3'b001;
      mem_w = 3'b000;
      for (int d = 0; d < 3; d++) begin
         addr[d]  = 32'h0;
         wdata[d] = 32'h0;
      end

      // Reset held two cycles with a load pending.
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
         chk("rst_ready", {31'b0, ready[0]}, 32'd0);
         chk("rst_err", {31'b0, err[0]}, 32'd0);
         chk("rst_rdata", rdata[0], 32'd0);
         chk("rst_stall_idle_req", {31'b0, stall[0]}, 32'd1);
      end
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      mem_r[0] = 1'b0;
      @(negedge clk);
      chk("post_rst_stall", {31'b0, stall[0]}, 32'd0);
      mon_en = 1'b1;
      @(negedge clk);
      chk("post_rst_idle_stall", {31'b0, stall[0]}, 32'd0);

      // Store then load, LATENCY 2.
      req(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 3);
      req(0, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3);

      // Rejected accesses, then readback proves memory untouched.
      req(0, 1'b1, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1);
      req(0, 1'b1, 1'b1, 32'h10, 32'h0BADF00D, 32'h0, 1'b1, 1);
      req(0, 1'b0, 1'b1, 32'h12, 32'h0BADF00D, 32'h0, 1'b1, 1);
      req(0, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3);

      // Aliasing modulo 4 KiB.
      req(0, 1'b0, 1'b1, 32'h1000, 32'h00001234, 32'h0, 1'b0, 3);
      req(0, 1'b1, 1'b0, 32'h0000, 32'h0, 32'h00001234, 1'b0, 3);
      req(0, 1'b0, 1'b1, 32'hFFC, 32'hCAFEF00D, 32'h0, 1'b0, 3);
      req(0, 1'b1, 1'b0, 32'hFFFF_3FFC, 32'h0, 32'hCAFEF00D, 1'b0, 3);

      // Reset during WAIT must abort the pending store.
      req(0, 1'b0, 1'b1, 32'h20, 32'h11111111, 32'h0, 1'b0, 3);
      @(posedge clk);
      #1;
      mem_w[0] = 1'b1;
      addr[0]  = 32'h20;
      wdata[0] = 32'hA5A5A5A5;
      @(negedge clk);
      chk("abort_stall_c0", {31'b0, stall[0]}, 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_stall_wait", {31'b0, stall[0]}, 32'd1);
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      mem_w[0] = 1'b0;
      repeat (3) @(posedge clk);
      req(0, 1'b1, 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0, 3);

      // LATENCY boundaries.
      req(1, 1'b0, 1'b1, 32'h4, 32'h00000055, 32'h0, 1'b0, 2);
      req(1, 1'b1, 1'b0, 32'h4, 32'h0, 32'h00000055, 1'b0, 2);
      req(1, 1'b1, 1'b0, 32'h5, 32'h0, 32'h0, 1'b1, 1);
      req(2, 1'b0, 1'b1, 32'h8, 32'h87654321, 32'h0, 1'b0, 16);
      req(2, 1'b1, 1'b0, 32'h8, 32'h0, 32'h87654321, 1'b0, 16);
      req(2, 1'b1, 1'b1, 32'h8, 32'h0, 32'h0, 1'b1, 1);

      repeat (4) @(posedge clk);
      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the processor datapath: the memory-side end of the load/store interface driven by the control unit's MemR/MemW outputs. It accepts one word-aligned load or store, models a fixed multi-cycle access latency, and holds `stall` high so the CPU freezes PC and register write-back until the access completes. A `ready` pulse then presents load data and commits the instruction.

## Interface
- `ADDR_W`, 10: word-address width; memory depth is 2^ADDR_W 32-bit words.
- `LATENCY`, 2: WAIT cycles per access; legal range 1..15.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `mem_r`  in  1  load request (from control MemR).
- `mem_w`  in  1  store request (from control MemW).
- `addr`  in  32  byte address from ALU result.
- `wdata`  in  32  store data (rt value).
- `rdata`  out  32  load data; valid only while `ready`=1.
- `ready`  out  1  one-cycle completion pulse.
- `stall`  out  1  freeze request to PC/regfile.
- `err`  out  1  access rejected; valid with `ready`.

## Operation
- Requester holds `mem_r`/`mem_w`, `addr` and `wdata` stable from the first request cycle until the `ready` cycle.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - No request: remain in IDLE.
  - Valid request (exactly one of `mem_r`/`mem_w`, `addr[1:0]`=0): latch op, index and data; load counter with LATENCY-1; go to WAIT.
  - Invalid request (both strobes high, or `addr[1:0]`≠0): go to RESP with `err`=1. No memory access; `rdata`=0.
- WAIT:
  - Counter≠0: decrement and stay.
  - Counter=0: perform the access on this edge and go to RESP.
    - Store: write `wdata` to word `addr[ADDR_W+1:2]`.
    - Load: register that word into `rdata`.
- RESP: `ready`=1 for exactly one cycle, then always return to IDLE. Request inputs are ignored during RESP; they belong to the instruction being committed.
- Address bits above ADDR_W+1 are ignored, so addresses alias modulo the memory size. Aliasing is not an error.
- A load immediately following a store to the same word returns the new data.
- Memory contents are not initialised by reset.

## Timing
- `stall` is combinational:
  - In IDLE: 1 when `mem_r|mem_w`, else 0.
  - In WAIT: 1.
  - In RESP: 0.
- Valid access: request seen in cycle 0; WAIT occupies cycles 1..LATENCY; `ready`, `rdata` and `err`=0 are presented in cycle LATENCY+1. Total LATENCY+2 cycles including the commit cycle.
- Invalid access: `ready`=1 and `err`=1 in cycle 1.
- Store is committed at the end of the last WAIT cycle.
- Reset values: state IDLE, counter 0, `ready`=0, `err`=0, `rdata`=0; `stall` follows its IDLE rule.
- Reset asserted mid-WAIT aborts the access; a store not yet committed is never written.
- `ready`, `err` and `rdata` are registered; `rdata` is 0 in every non-RESP cycle.

## Structure
- Shared package `dmem_pkg`:
  - FSM state enum (IDLE, WAIT, RESP).
  - Default LATENCY and ADDR_W constants.
  - Word-index extraction helper constant (byte offset width 2).
- One sub-module, `dmem_array`: single-port 2^ADDR_W×32 array with synchronous write and registered read, one port `we`/`re`. The responder owns the FSM, counter and error checks.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `mem_r`=1 → `ready`=0, `err`=0, `rdata`=0; state IDLE after release.
- Store then load, LATENCY=2:
  - Store 0xDEADBEEF to `addr`=0x10 → `stall`=1 for cycles 0..2, `ready` in cycle 3.
  - Next-cycle load from 0x10 → `rdata`=0xDEADBEEF with `ready` in cycle 3, `err`=0.
- Errors:
  - Load at `addr`=0x13 → `ready`=`err`=1 in cycle 1, `rdata`=0.
  - `mem_r`=`mem_w`=1 → same response; memory unchanged on readback.
- Aliasing, ADDR_W=10: store 0x1234 to 0x1000, load 0x0000 → 0x1234.
- Reset mid-access: store 0xA5A5A5A5 to 0x20, assert `rst_n`=0 in cycle 1; later load 0x20 → prior value returned.
- Boundaries: LATENCY=1 → `ready` in cycle 2; LATENCY=15 → `ready` in cycle 16; `stall` low exactly in the `ready` cycle both times.
